multi_alarm_clock: RTL and testbench

- Parametrised successor to the single-alarm clock core.
- Keeps time (sec/min/hrs/day-of-week) from a 1 s tick and holds NUM_ALARMS independent alarms.
- Each alarm has its own weekday mask, snooze and ring timeout.
- Outputs binary time fields for the 7-seg decoder stage, plus per-alarm and combined buzz.

---
 rtl/alarm_pkg.sv | 34 +++
 rtl/alarm_channel.sv | 158 +++++++++++++++
 rtl/multi_alarm_clock.sv | 158 +++++++++++++++
 tb/tb_multi_alarm_clock.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and constants for the multi-alarm clock.
//   alarm_state_t : per-channel alarm FSM state
//   time_t        : packed wall-clock time (day, hrs, min, sec)
//   *_MAX         : wrap limits of each time field
//   timer_width() : bit width of a seconds down-counter covering both ring and snooze
package alarm_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRinging = 2'd1,
    StSnoozed = 2'd2
  } alarm_state_t;

  typedef struct packed {
    logic [2:0] day;
    logic [4:0] hrs;
    logic [5:0] min;
    logic [5:0] sec;
  } time_t;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;
  localparam int unsigned HRS_MAX = 23;
  localparam int unsigned DAY_MAX = 6;

  // Width needed to hold the longer of the two timeouts, expressed in seconds.
  function automatic int unsigned timer_width(input int unsigned ring_min,
                                              input int unsigned snooze_min);
    int unsigned max_sec;
    max_sec = ((ring_min > snooze_min) ? ring_min : snooze_min) * 60;
    return (max_sec < 2) ? 1 : $clog2(max_sec + 1);
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: alarm time, weekday mask, ring/snooze timers and the FSM.
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   pulse_i            : 1 s tick
//   enable_i           : channel enable; low forces idle
//   adv_min_i/adv_hrs_i: advance alarm minutes/hours (already qualified by tick and select)
//   mask_wr_i, mask_i  : weekday mask write strobe and data
//   eval_i             : current time just entered HH:MM:00 in run mode
//   cur_min_i/hrs/day  : current time
//   snooze_i, ack_i    : user controls
//   alarm_min_o/hrs_o  : alarm time for display
//   buzz_o             : registered ring output
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int unsigned SnoozeMin   = 9,
  parameter int unsigned RingMin     = 5,
  parameter int unsigned MaxSnooze   = 3,
  parameter logic [6:0]  DefaultMask = 7'b0011111
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pulse_i,
  input  logic       enable_i,
  input  logic       adv_min_i,
  input  logic       adv_hrs_i,
  input  logic       mask_wr_i,
  input  logic [6:0] mask_i,
  input  logic       eval_i,
  input  logic [5:0] cur_min_i,
  input  logic [4:0] cur_hrs_i,
  input  logic [2:0] cur_day_i,
  input  logic       snooze_i,
  input  logic       ack_i,
  output logic [5:0] alarm_min_o,
  output logic [4:0] alarm_hrs_o,
  output logic       buzz_o
);

  localparam int unsigned TW = timer_width(RingMin, SnoozeMin);
  localparam int unsigned CW = (MaxSnooze < 1) ? 1 : $clog2(MaxSnooze + 1);

  localparam logic [TW-1:0] RingLoad   = TW'(RingMin * 60);
  localparam logic [TW-1:0] SnoozeLoad = TW'(SnoozeMin * 60);
  localparam logic [CW-1:0] MaxCnt     = CW'(MaxSnooze);

  alarm_state_t  state_q;
  logic [TW-1:0] timer_q;
  logic [CW-1:0] snooze_cnt_q;
  logic          buzz_q;
  logic [5:0]    alarm_min_q;
  logic [4:0]    alarm_hrs_q;
  logic [6:0]    mask_q;
  logic [7:0]    mask_ext;
  logic          match;

  // Padded so a 3-bit day index never selects outside the vector.
  assign mask_ext = {1'b0, mask_q};

  assign match = eval_i & enable_i & mask_ext[cur_day_i] &
                 (cur_min_i == alarm_min_q) & (cur_hrs_i == alarm_hrs_q);

  // Alarm time and weekday mask.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alarm_min_q <= '0;
      alarm_hrs_q <= '0;
      mask_q      <= DefaultMask;
    end else begin
      if (mask_wr_i) begin
        mask_q <= mask_i;
      end
      if (adv_min_i) begin
        alarm_min_q <= (alarm_min_q == 6'(MIN_MAX)) ? 6'd0 : alarm_min_q + 6'd1;
      end
      if (adv_hrs_i) begin
        alarm_hrs_q <= (alarm_hrs_q == 5'(HRS_MAX)) ? 5'd0 : alarm_hrs_q + 5'd1;
      end
    end
  end

  // Ring FSM. Controls are level-sensitive, but each acts only in the state it
  // leaves, so a held level fires once per state entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      timer_q      <= '0;
      snooze_cnt_q <= '0;
      buzz_q       <= 1'b0;
    end else if (!enable_i) begin
      state_q <= StIdle;
      timer_q <= '0;
      buzz_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (match) begin
            state_q      <= StRinging;
            timer_q      <= RingLoad;
            snooze_cnt_q <= '0;
            buzz_q       <= 1'b1;
          end
        end
        StRinging: begin
          if (ack_i) begin
            state_q <= StIdle;
            buzz_q  <= 1'b0;
          end else if (snooze_i) begin
            if (snooze_cnt_q < MaxCnt) begin
              state_q      <= StSnoozed;
              timer_q      <= SnoozeLoad;
              snooze_cnt_q <= snooze_cnt_q + 1'b1;
            end else begin
              state_q <= StIdle;
            end
            buzz_q <= 1'b0;
          end else if (match) begin
            timer_q <= RingLoad;
          end else if (pulse_i) begin
            if (timer_q <= TW'(1)) begin
              state_q <= StIdle;
              timer_q <= '0;
              buzz_q  <= 1'b0;
            end else begin
              timer_q <= timer_q - 1'b1;
            end
          end
        end
        StSnoozed: begin
          if (ack_i) begin
            state_q <= StIdle;
            buzz_q  <= 1'b0;
          end else if (match) begin
            state_q <= StRinging;
            timer_q <= RingLoad;
            buzz_q  <= 1'b1;
          end else if (pulse_i) begin
            if (timer_q <= TW'(1)) begin
              state_q <= StRinging;
              timer_q <= RingLoad;
              buzz_q  <= 1'b1;
            end else begin
              timer_q <= timer_q - 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          buzz_q  <= 1'b0;
        end
      endcase
    end
  end

  assign alarm_min_o = alarm_min_q;
  assign alarm_hrs_o = alarm_hrs_q;
  assign buzz_o      = buzz_q;

endmodule

// File: rtl/multi_alarm_clock.sv
// Multi-alarm clock core: timekeeping chain, time/alarm set logic, display mux
// and NUM_ALARMS independent alarm channels.
//   Clk, Reset_n         : clock, asynchronous active-low reset
//   Pulse                : 1 s tick, one Clk wide
//   Timeset, Alarmset    : set modes (Timeset has priority)
//   Alarmsel             : channel addressed by alarm set and mask writes
//   Minadv/Hrsadv/Dayadv : advance controls, acted on per Pulse
//   Daymask_wr/Daymask_in: weekday mask write to the selected channel
//   Alarmon              : per-channel enable
//   Snooze, Ack          : broadcast to all channels
//   Disp_*               : binary display fields
//   Buzz, Buzz_any       : per-channel ring and its OR
module multi_alarm_clock
  import alarm_pkg::*;
#(
  parameter int unsigned NUM_ALARMS   = 4,
  parameter int unsigned SNOOZE_MIN   = 9,
  parameter int unsigned RING_MIN     = 5,
  parameter int unsigned MAX_SNOOZE   = 3,
  parameter logic [6:0]  DEFAULT_MASK = 7'b0011111,
  localparam int unsigned SEL_W       = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  Pulse,
  input  logic                  Timeset,
  input  logic                  Alarmset,
  input  logic [SEL_W-1:0]      Alarmsel,
  input  logic                  Minadv,
  input  logic                  Hrsadv,
  input  logic                  Dayadv,
  input  logic                  Daymask_wr,
  input  logic [6:0]            Daymask_in,
  input  logic [NUM_ALARMS-1:0] Alarmon,
  input  logic                  Snooze,
  input  logic                  Ack,
  output logic [5:0]            Disp_sec,
  output logic [5:0]            Disp_min,
  output logic [4:0]            Disp_hrs,
  output logic [2:0]            Disp_day,
  output logic [NUM_ALARMS-1:0] Buzz,
  output logic                  Buzz_any
);

  time_t      now_q;
  logic       eval_q;
  logic       alarm_mode;
  logic       eval;
  logic [5:0] alarm_min [NUM_ALARMS];
  logic [4:0] alarm_hrs [NUM_ALARMS];
  logic [5:0] sel_min;
  logic [4:0] sel_hrs;

  assign alarm_mode = Alarmset & ~Timeset;

  // Timekeeping. eval_q flags the cycle after the time entered HH:MM:00 in run
  // mode; alarm matching happens on that cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      now_q  <= '0;
      eval_q <= 1'b0;
    end else begin
      eval_q <= 1'b0;
      if (Timeset) begin
        now_q.sec <= '0;
        if (Pulse) begin
          if (Minadv) begin
            now_q.min <= (now_q.min == 6'(MIN_MAX)) ? 6'd0 : now_q.min + 6'd1;
          end
          if (Hrsadv) begin
            now_q.hrs <= (now_q.hrs == 5'(HRS_MAX)) ? 5'd0 : now_q.hrs + 5'd1;
          end
          if (Dayadv) begin
            now_q.day <= (now_q.day == 3'(DAY_MAX)) ? 3'd0 : now_q.day + 3'd1;
          end
        end
      end else if (Pulse) begin
        if (now_q.sec == 6'(SEC_MAX)) begin
          now_q.sec <= '0;
          eval_q    <= 1'b1;
          if (now_q.min == 6'(MIN_MAX)) begin
            now_q.min <= '0;
            if (now_q.hrs == 5'(HRS_MAX)) begin
              now_q.hrs <= '0;
              now_q.day <= (now_q.day == 3'(DAY_MAX)) ? 3'd0 : now_q.day + 3'd1;
            end else begin
              now_q.hrs <= now_q.hrs + 5'd1;
            end
          end else begin
            now_q.min <= now_q.min + 6'd1;
          end
        end else begin
          now_q.sec <= now_q.sec + 6'd1;
        end
      end
    end
  end

  // Entering Timeset right after a carry cancels that minute's evaluation.
  assign eval = eval_q & ~Timeset & (now_q.sec == 6'd0);

  for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_ch
    logic sel;
    assign sel = (Alarmsel == SEL_W'(g));

    alarm_channel #(
      .SnoozeMin   (SNOOZE_MIN),
      .RingMin     (RING_MIN),
      .MaxSnooze   (MAX_SNOOZE),
      .DefaultMask (DEFAULT_MASK)
    ) u_ch (
      .clk_i       (Clk),
      .rst_ni      (Reset_n),
      .pulse_i     (Pulse),
      .enable_i    (Alarmon[g]),
      .adv_min_i   (Pulse & alarm_mode & Minadv & sel),
      .adv_hrs_i   (Pulse & alarm_mode & Hrsadv & sel),
      .mask_wr_i   (Daymask_wr & sel),
      .mask_i      (Daymask_in),
      .eval_i      (eval),
      .cur_min_i   (now_q.min),
      .cur_hrs_i   (now_q.hrs),
      .cur_day_i   (now_q.day),
      .snooze_i    (Snooze),
      .ack_i       (Ack),
      .alarm_min_o (alarm_min[g]),
      .alarm_hrs_o (alarm_hrs[g]),
      .buzz_o      (Buzz[g])
    );
  end

  // Selected alarm time; an out-of-range select shows 00:00.
  always_comb begin
    sel_min = '0;
    sel_hrs = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (Alarmsel == SEL_W'(i)) begin
        sel_min = alarm_min[i];
        sel_hrs = alarm_hrs[i];
      end
    end
  end

  always_comb begin
    Disp_sec = now_q.sec;
    Disp_min = now_q.min;
    Disp_hrs = now_q.hrs;
    if (alarm_mode) begin
      Disp_sec = '0;
      Disp_min = sel_min;
      Disp_hrs = sel_hrs;
    end
  end

  assign Disp_day = now_q.day;
  assign Buzz_any = |Buzz;

endmodule

// File: tb/tb_multi_alarm_clock.sv
module tb_multi_alarm_clock;

  logic       Clk;
  logic       Reset_n;
  logic       Pulse;
  logic       Timeset;
  logic       Alarmset;
  logic [1:0] Alarmsel;
  logic       Minadv;
  logic       Hrsadv;
  logic       Dayadv;
  logic       Daymask_wr;
  logic [6:0] Daymask_in;
  logic [3:0] Alarmon;
  logic       Snooze;
  logic       Ack;
  logic [5:0] Disp_sec;
  logic [5:0] Disp_min;
  logic [4:0] Disp_hrs;
  logic [2:0] Disp_day;
  logic [3:0] Buzz;
  logic       Buzz_any;

  int n_tests = 0;
  int n_fail  = 0;
  int run_secs = 0;

  multi_alarm_clock dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Pulse      (Pulse),
    .Timeset    (Timeset),
    .Alarmset   (Alarmset),
    .Alarmsel   (Alarmsel),
    .Minadv     (Minadv),
    .Hrsadv     (Hrsadv),
    .Dayadv     (Dayadv),
    .Daymask_wr (Daymask_wr),
    .Daymask_in (Daymask_in),
    .Alarmon    (Alarmon),
    .Snooze     (Snooze),
    .Ack        (Ack),
    .Disp_sec   (Disp_sec),
    .Disp_min   (Disp_min),
    .Disp_hrs   (Disp_hrs),
    .Disp_day   (Disp_day),
    .Buzz       (Buzz),
    .Buzz_any   (Buzz_any)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic       ts;
    logic       as;
    logic       ma;
    logic       ha;
    logic       da;
    int         n;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hrs;
    logic [2:0] day;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_disp(input string name, input logic [5:0] s, input logic [5:0] m,
                            input logic [4:0] h, input logic [2:0] d);
    check(name, {12'd0, Disp_day, Disp_hrs, Disp_min, Disp_sec}, {12'd0, d, h, m, s});
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic pulses(input int n);
    for (int k = 0; k < n; k++) begin
      Pulse = 1'b1;
      cyc();
      Pulse = 1'b0;
      cyc();
    end
  endtask

  task automatic do_reset();
    Pulse = 0; Timeset = 0; Alarmset = 0; Alarmsel = 0; Minadv = 0; Hrsadv = 0;
    Dayadv = 0; Daymask_wr = 0; Daymask_in = 0; Alarmon = 0; Snooze = 0; Ack = 0;
    Reset_n = 1'b0;
    cyc();
    cyc();
    Reset_n = 1'b1;
    cyc();
    run_secs = 0;
  endtask

  // Alarm set runs the clock; run_secs tracks how far it got from 00:00:00.
  task automatic set_alarm(input int sel, input int h, input int m);
    int n;
    n = (h > m) ? h : m;
    Alarmset = 1'b1;
    Alarmsel = 2'(sel);
    for (int k = 0; k < n; k++) begin
      Hrsadv = (k < h);
      Minadv = (k < m);
      pulses(1);
    end
    Hrsadv = 0; Minadv = 0; Alarmset = 0;
    run_secs += n;
  endtask

  task automatic write_mask(input int sel, input logic [6:0] m);
    Alarmsel   = 2'(sel);
    Daymask_in = m;
    Daymask_wr = 1'b1;
    cyc();
    Daymask_wr = 1'b0;
  endtask

  // Set time to h:m:00 day d (clock assumed below 01:00 since reset), then run s seconds.
  task automatic goto_time(input int h, input int m, input int d, input int s);
    int nm;
    int n;
    nm = (m - run_secs / 60 + 60) % 60;
    n  = h;
    if (nm > n) n = nm;
    if (d > n) n = d;
    Timeset = 1'b1;
    for (int k = 0; k < n; k++) begin
      Hrsadv = (k < h);
      Minadv = (k < nm);
      Dayadv = (k < d);
      pulses(1);
    end
    Hrsadv = 0; Minadv = 0; Dayadv = 0;
    Timeset = 1'b0;
    pulses(s);
  endtask

  // Alarm 0 at 08:01, day 4, ends ringing.
  task automatic arm_ring();
    do_reset();
    set_alarm(0, 8, 1);
    goto_time(8, 0, 4, 59);
    Alarmon = 4'b0001;
    pulses(1);
    check("arm_ring", Buzz, 4'b0001);
  endtask

  initial begin
    vecs[0]  = '{1, 0, 1, 0, 0, 62, 0, 2, 0, 0};
    vecs[1]  = '{1, 0, 0, 1, 0, 25, 0, 2, 1, 0};
    vecs[2]  = '{1, 0, 0, 0, 1, 8, 0, 2, 1, 1};
    vecs[3]  = '{1, 0, 1, 1, 1, 3, 0, 5, 4, 4};
    vecs[4]  = '{0, 0, 0, 0, 0, 10, 10, 5, 4, 4};
    vecs[5]  = '{0, 0, 1, 0, 0, 50, 0, 6, 4, 4};
    vecs[6]  = '{1, 0, 1, 0, 0, 54, 0, 0, 4, 4};
    vecs[7]  = '{1, 0, 0, 1, 0, 19, 0, 0, 23, 4};
    vecs[8]  = '{1, 0, 1, 0, 0, 59, 0, 59, 23, 4};
    vecs[9]  = '{0, 0, 0, 0, 0, 60, 0, 0, 0, 5};
    vecs[10] = '{1, 0, 0, 0, 1, 2, 0, 0, 0, 0};
    vecs[11] = '{0, 1, 0, 1, 0, 3, 0, 0, 3, 0};
    vecs[12] = '{1, 1, 1, 0, 0, 1, 0, 1, 0, 0};
    vecs[13] = '{0, 1, 1, 0, 1, 1, 0, 1, 3, 0};
    vecs[14] = '{0, 0, 0, 0, 0, 1, 2, 1, 0, 0};

    // Reset state
    do_reset();
    check_disp("reset_disp", 0, 0, 0, 0);
    check("reset_buzz", {Buzz_any, Buzz}, 5'b0);

    // Time/alarm set and run vectors, cumulative from reset
    for (int i = 0; i < 15; i++) begin
      Timeset  = vecs[i].ts;
      Alarmset = vecs[i].as;
      Minadv   = vecs[i].ma;
      Hrsadv   = vecs[i].ha;
      Dayadv   = vecs[i].da;
      pulses(vecs[i].n);
      Minadv = 0; Hrsadv = 0; Dayadv = 0;
      check_disp($sformatf("vec%0d", i), vecs[i].sec, vecs[i].min, vecs[i].hrs, vecs[i].day);
      check($sformatf("vec%0d_buzz", i), Buzz, 4'b0);
    end
    Timeset = 0; Alarmset = 0;

    // Alarm 0 at 08:01, day 4: exact rise timing
    do_reset();
    set_alarm(0, 8, 1);
    goto_time(8, 0, 4, 55);
    Alarmon = 4'b0001;
    pulses(4);
    check("pre_match_buzz", Buzz, 4'b0);
    Pulse = 1'b1;
    cyc();
    Pulse = 1'b0;
    check_disp("match_edge_time", 0, 1, 8, 4);
    check("match_edge_buzz", Buzz, 4'b0);
    cyc();
    check("match_buzz", {Buzz_any, Buzz}, 5'b10001);
    Ack = 1'b1;
    cyc();
    Ack = 1'b0;
    check("ack_buzz", Buzz, 4'b0);

    // Day 5 is masked by default
    Timeset = 1'b1;
    for (int k = 0; k < 59; k++) begin
      Minadv = 1'b1;
      Dayadv = (k == 0);
      pulses(1);
    end
    Minadv = 0; Dayadv = 0; Timeset = 0;
    pulses(60);
    check_disp("day5_time", 0, 1, 8, 5);
    check("day5_masked", Buzz, 4'b0);
    write_mask(0, 7'b1111111);
    Timeset = 1'b1;
    Minadv  = 1'b1;
    pulses(59);
    Minadv = 0; Timeset = 0;
    pulses(60);
    check("day5_unmasked", Buzz, 4'b0001);

    // Snooze three times, fourth snooze silences
    for (int s = 1; s <= 3; s++) begin
      Snooze = 1'b1;
      cyc();
      Snooze = 1'b0;
      check($sformatf("snooze%0d_off", s), Buzz, 4'b0);
      pulses(539);
      check($sformatf("snooze%0d_539", s), Buzz, 4'b0);
      pulses(1);
      check($sformatf("snooze%0d_540", s), Buzz, 4'b0001);
    end
    Snooze = 1'b1;
    cyc();
    Snooze = 1'b0;
    check("snooze4_off", Buzz, 4'b0);
    pulses(540);
    check("snooze4_idle", Buzz, 4'b0);

    // Snooze and Ack together: Ack wins
    arm_ring();
    Snooze = 1'b1;
    Ack    = 1'b1;
    cyc();
    Snooze = 0; Ack = 0;
    check("snz_ack_off", Buzz, 4'b0);
    pulses(540);
    check("snz_ack_idle", Buzz, 4'b0);

    // Ring timeout after 300 s
    arm_ring();
    pulses(299);
    check("ring_299", Buzz, 4'b0001);
    pulses(1);
    check("ring_300", {Buzz_any, Buzz}, 5'b0);

    // Disable while ringing
    arm_ring();
    Alarmon = 4'b0;
    cyc();
    check("alarmon_off", Buzz, 4'b0);

    // Asynchronous reset mid-ring
    arm_ring();
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    check("reset_mid_ring", {Buzz_any, Buzz}, 5'b0);
    cyc();
    Reset_n = 1'b1;
    cyc();
    cyc();
    check("after_reset_ring", {Buzz_any, Buzz}, 5'b0);

    // Two channels at 23:59 on Sunday, day wrap
    do_reset();
    set_alarm(0, 23, 59);
    set_alarm(2, 23, 59);
    write_mask(0, 7'b1111111);
    write_mask(2, 7'b1111111);
    goto_time(23, 58, 6, 59);
    Alarmon = 4'b0101;
    pulses(1);
    check_disp("dual_time", 0, 59, 23, 6);
    check("dual_buzz", {Buzz_any, Buzz}, 5'b10101);
    pulses(60);
    check_disp("wrap_time", 0, 0, 0, 0);
    check("wrap_buzz", {Buzz_any, Buzz}, 5'b10101);
    Ack = 1'b1;
    cyc();
    Ack = 1'b0;
    check("dual_ack", {Buzz_any, Buzz}, 5'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
